alu_pipe: RTL

- Parametrised successor of the 4-bit registered ALU datapath: a WIDTH-bit, two-stage pipelined ALU.
- Extends the operation set to 8 ops with carry/zero flags and adds a valid/ready handshake with backpressure.
- Adds a sleep/drain handshake so a power controller can safely isolate the ALU domain.
- Sits between pad-side input registers and the output pad register path inside the top-level power-aware datapath.

---
 rtl/alu_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Two-stage WIDTH-bit ALU with valid/ready flow control
// and a sleep/drain handshake for power isolation.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   in_valid/in_ready   operand beat handshake (in1, in2, sel)
//   out_valid/out_ready result handshake (out1, carry, zero)
//   sleep_req/sleep_ack power controller drain/isolate handshake
//   busy                any stage holds a beat
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic             carry,
  output logic             zero,
  input  logic             sleep_req,
  output logic             sleep_ack,
  output logic             busy
);

  typedef enum logic [1:0] {
    RUN, DRAIN, SLEEP, WAKE
  } state_t;

  state_t state, state_n;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_sel;

  logic             s2_valid;
  logic [WIDTH-1:0] out1_q;
  logic             carry_q;
  logic             zero_q;

  logic             s2_take;
  logic             accept;
  logic             drain_done;
  logic             go_sleep;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic [SHW-1:0]   shamt;

  // S2 can take a new beat when empty or being consumed
  assign s2_take  = ~s2_valid | out_ready;
  assign in_ready = (state == RUN)
                  & (~s1_valid | s2_take);
  assign accept   = in_valid & in_ready;

  // pipeline will be empty after this edge
  // (S1 cannot load outside RUN)
  assign drain_done = ~s1_valid & s2_take;
  assign go_sleep   = (state == DRAIN)
                    & sleep_req & drain_done;

  assign shamt = s1_b[SHW-1:0];

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    unique case (s1_sel)
      3'd0: {res_c, res} = {1'b0, s1_a}
                         + {1'b0, s1_b};
      3'd1: {res_c, res} = {1'b0, s1_a}
                         - {1'b0, s1_b};
      3'd2: res = s1_a & s1_b;
      3'd3: res = s1_a | s1_b;
      3'd4: res = s1_a ^ s1_b;
      3'd5: res = s1_a << shamt;
      3'd6: res = s1_a >> shamt;
      3'd7: res = s1_a;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUN: begin
        if (sleep_req) state_n = DRAIN;
      end
      DRAIN: begin
        if (!sleep_req)      state_n = RUN;
        else if (drain_done) state_n = SLEEP;
      end
      SLEEP: begin
        if (!sleep_req) state_n = WAKE;
      end
      WAKE: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= in1;
      s1_b     <= in2;
      s1_sel   <= sel;
    end else if (s2_take) begin
      s1_valid <= 1'b0;
    end
  end

  // result registers are cleared on sleep entry so
  // the isolated outputs sit at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      out1_q   <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      if (s2_take) s2_valid <= s1_valid;
      if (go_sleep) begin
        out1_q  <= '0;
        carry_q <= 1'b0;
        zero_q  <= 1'b0;
      end else if (s2_take & s1_valid) begin
        out1_q  <= res;
        carry_q <= res_c;
        zero_q  <= (res == '0);
      end
    end
  end

  assign out_valid = s2_valid;
  assign out1      = out1_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign sleep_ack = (state == SLEEP);
  assign busy      = s1_valid | s2_valid;

endmodule
